// File: rtl/cfi_pkg.sv
`default_nettype none
// cfi_pkg: shared types and constants for the CFI policy controller.
package cfi_pkg;

  localparam int unsigned CFI_NR_VIOL = 2;

  typedef enum logic [1:0] {
    CFI_IDLE     = 2'd0,
    CFI_WAIT_ARM = 2'd1,
    CFI_ACTIVE   = 2'd2,
    CFI_TRAP     = 2'd3
  } cfi_state_e;

  localparam logic [1:0] CFI_CTRL   = 2'd0;
  localparam logic [1:0] CFI_STATUS = 2'd1;
  localparam logic [1:0] CFI_CNT    = 2'd2;
  localparam logic [1:0] CFI_THR    = 2'd3;

  localparam int unsigned CTRL_ENABLE   = 0;
  localparam int unsigned CTRL_HALT_EN  = 1;
  localparam int unsigned CTRL_IRQ_EN   = 2;
  localparam int unsigned CTRL_AUTO_ARM = 3;

endpackage
`default_nettype wire

// File: rtl/cfi_policy_ctrl_if.sv
`default_nettype none
// cfi_policy_ctrl_if: software configuration port (write strobe, address, data, read data).
interface cfi_policy_ctrl_if;
  logic        cfg_we_i;
  logic [1:0]  cfg_addr_i;
  logic [31:0] cfg_wdata_i;
  logic [31:0] cfg_rdata_o;

  modport master (output cfg_we_i, output cfg_addr_i, output cfg_wdata_i, input cfg_rdata_o);
  modport slave  (input cfg_we_i, input cfg_addr_i, input cfg_wdata_i, output cfg_rdata_o);
endinterface
`default_nettype wire

// File: rtl/cfi_sat_counter.sv
`default_nettype none
// cfi_sat_counter: saturating up-counter; a clear restarts from the same-cycle increment.
module cfi_sat_counter #(
  parameter int unsigned CNT_W = 16,
  parameter int unsigned ADD_W = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic [ADD_W-1:0] add_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic [CNT_W-1:0] cnt_next_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W:0]   sum;

  always_comb begin
    sum = {1'b0, cnt_q} + (CNT_W+1)'(add_i);
    if (clr_i) begin
      cnt_d = CNT_W'(add_i);
    end else if (sum[CNT_W]) begin
      cnt_d = '1;
    end else begin
      cnt_d = sum[CNT_W-1:0];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o      = cnt_q;
  assign cnt_next_o = cnt_d;

endmodule
`default_nettype wire

// File: rtl/cfi_policy_ctrl.sv
`default_nettype none
// cfi_policy_ctrl: enable/arm sequencing, violation accounting and trap handshake
// for the CFI commit monitor, configured through a 4-register port.
module cfi_policy_ctrl
  import cfi_pkg::*;
#(
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned NR_VIOL = CFI_NR_VIOL
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  cfi_policy_ctrl_if.slave   cfg,
  input  logic               arm_marker_i,
  input  logic [NR_VIOL-1:0] viol_i,
  output logic               monitor_en_o,
  output logic               commit_stall_o,
  output logic               exc_req_o,
  input  logic               exc_ack_i,
  output logic               irq_o,
  output logic [1:0]         state_o
);

  localparam int unsigned ADD_W = $clog2(NR_VIOL + 1);

  cfi_state_e       state_q, state_d;
  logic [3:0]       ctrl_q, ctrl_d;
  logic             sticky_q, sticky_d;
  logic [NR_VIOL-1:0] cause_q, cause_d;
  logic             trapped_q, trapped_d;
  logic [CNT_W-1:0] thr_q, thr_d, thr_eff;
  logic [CNT_W-1:0] cnt_q, cnt_next;
  logic [NR_VIOL-1:0] viol_act;
  logic [ADD_W-1:0] viol_add;
  logic             monitor_en_q, stall_q, irq_q;
  logic             wr_ctrl, wr_status, wr_cnt, wr_thr, trap_ack;
  logic             unused_wdata;

  assign wr_ctrl   = cfg.cfg_we_i && (cfg.cfg_addr_i == CFI_CTRL);
  assign wr_status = cfg.cfg_we_i && (cfg.cfg_addr_i == CFI_STATUS);
  assign wr_cnt    = cfg.cfg_we_i && (cfg.cfg_addr_i == CFI_CNT);
  assign wr_thr    = cfg.cfg_we_i && (cfg.cfg_addr_i == CFI_THR);
  assign unused_wdata = ^cfg.cfg_wdata_i[31:CNT_W];

  // Violations only count while the monitor is actively checking.
  assign viol_act = (state_q == CFI_ACTIVE) ? viol_i : '0;

  always_comb begin
    viol_add = '0;
    for (int i = 0; i < int'(NR_VIOL); i++) begin
      viol_add = viol_add + ADD_W'(viol_act[i]);
    end
  end

  cfi_sat_counter #(
    .CNT_W (CNT_W),
    .ADD_W (ADD_W)
  ) u_viol_cnt (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .clr_i      (wr_cnt),
    .add_i      (viol_add),
    .cnt_o      (cnt_q),
    .cnt_next_o (cnt_next)
  );

  assign thr_eff = (thr_q == '0) ? CNT_W'(1) : thr_q;

  always_comb begin
    state_d  = state_q;
    trap_ack = 1'b0;
    case (state_q)
      CFI_IDLE: begin
        if (ctrl_q[CTRL_ENABLE]) begin
          state_d = ctrl_q[CTRL_AUTO_ARM] ? CFI_WAIT_ARM : CFI_ACTIVE;
        end
      end
      CFI_WAIT_ARM: begin
        if (!ctrl_q[CTRL_ENABLE]) begin
          state_d = CFI_IDLE;
        end else if (arm_marker_i) begin
          state_d = CFI_ACTIVE;
        end
      end
      CFI_ACTIVE: begin
        if (!ctrl_q[CTRL_ENABLE]) begin
          state_d = CFI_IDLE;
        end else if (ctrl_q[CTRL_HALT_EN] && (|viol_act) && (cnt_next >= thr_eff)) begin
          state_d = CFI_TRAP;
        end
      end
      CFI_TRAP: begin
        if (exc_ack_i) begin
          trap_ack = 1'b1;
          state_d  = ctrl_q[CTRL_AUTO_ARM] ? CFI_WAIT_ARM : CFI_ACTIVE;
        end
      end
      default: state_d = CFI_IDLE;
    endcase
  end

  // STATUS is write-1-to-clear with hardware sets taking precedence.
  always_comb begin
    ctrl_d    = wr_ctrl ? cfg.cfg_wdata_i[3:0] : ctrl_q;
    thr_d     = wr_thr ? cfg.cfg_wdata_i[CNT_W-1:0] : thr_q;
    sticky_d  = (sticky_q & ~(wr_status & cfg.cfg_wdata_i[0])) | (|viol_act);
    cause_d   = (cause_q & ~({NR_VIOL{wr_status}} & cfg.cfg_wdata_i[NR_VIOL:1])) | viol_act;
    trapped_d = (trapped_q & ~(wr_status & cfg.cfg_wdata_i[NR_VIOL+1])) | trap_ack;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= CFI_IDLE;
      ctrl_q       <= '0;
      thr_q        <= CNT_W'(1);
      sticky_q     <= 1'b0;
      cause_q      <= '0;
      trapped_q    <= 1'b0;
      monitor_en_q <= 1'b0;
      stall_q      <= 1'b0;
      irq_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      ctrl_q       <= ctrl_d;
      thr_q        <= thr_d;
      sticky_q     <= sticky_d;
      cause_q      <= cause_d;
      trapped_q    <= trapped_d;
      monitor_en_q <= (state_d == CFI_ACTIVE);
      stall_q      <= (state_d == CFI_TRAP);
      irq_q        <= ctrl_d[CTRL_IRQ_EN] & sticky_d;
    end
  end

  always_comb begin
    cfg.cfg_rdata_o = '0;
    case (cfg.cfg_addr_i)
      CFI_CTRL:   cfg.cfg_rdata_o = 32'(ctrl_q);
      CFI_STATUS: cfg.cfg_rdata_o = 32'({trapped_q, cause_q, sticky_q});
      CFI_CNT:    cfg.cfg_rdata_o = 32'(cnt_q);
      CFI_THR:    cfg.cfg_rdata_o = 32'(thr_q);
      default:    cfg.cfg_rdata_o = '0;
    endcase
  end

  assign monitor_en_o   = monitor_en_q;
  assign commit_stall_o = stall_q;
  assign exc_req_o      = stall_q;
  assign irq_o          = irq_q;
  assign state_o        = state_q;

endmodule
`default_nettype wire

// File: tb/tb_cfi_policy_ctrl.sv
`default_nettype none
// tb_cfi_policy_ctrl: directed self-checking bench for cfi_policy_ctrl.
module tb_cfi_policy_ctrl;

  logic       clk = 1'b0;
  logic       rst_ni = 1'b0;
  logic       arm_marker_i = 1'b0;
  logic [1:0] viol_i = 2'b00;
  logic       exc_ack_i = 1'b0;
  logic       monitor_en_o, commit_stall_o, exc_req_o, irq_o;
  logic [1:0] state_o;
  int         checks = 0;
  int         errors = 0;

  cfi_policy_ctrl_if cfg_if ();

  cfi_policy_ctrl #(
    .CNT_W   (16),
    .NR_VIOL (2)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_ni),
    .cfg            (cfg_if),
    .arm_marker_i   (arm_marker_i),
    .viol_i         (viol_i),
    .monitor_en_o   (monitor_en_o),
    .commit_stall_o (commit_stall_o),
    .exc_req_o      (exc_req_o),
    .exc_ack_i      (exc_ack_i),
    .irq_o          (irq_o),
    .state_o        (state_o)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cfg_wr(input logic [1:0] a, input logic [31:0] d);
    cfg_if.cfg_we_i    = 1'b1;
    cfg_if.cfg_addr_i  = a;
    cfg_if.cfg_wdata_i = d;
    step();
    cfg_if.cfg_we_i    = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [1:0] a, input logic [31:0] exp);
    cfg_if.cfg_addr_i = a;
    @(negedge clk);
    chk(tag, cfg_if.cfg_rdata_o, exp);
  endtask

  task automatic chk_outs(input string tag, input logic [1:0] st, input logic men,
                          input logic stall, input logic req, input logic irq);
    chk({tag, "_state"}, 32'(state_o), 32'(st));
    chk({tag, "_mon"},   32'(monitor_en_o), 32'(men));
    chk({tag, "_stall"}, 32'(commit_stall_o), 32'(stall));
    chk({tag, "_req"},   32'(exc_req_o), 32'(req));
    chk({tag, "_irq"},   32'(irq_o), 32'(irq));
  endtask

  initial begin
    cfg_if.cfg_we_i    = 1'b0;
    cfg_if.cfg_addr_i  = 2'd0;
    cfg_if.cfg_wdata_i = 32'd0;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk_outs("rst", 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    rd_chk("rst_ctrl", 2'd0, 32'h0);
    rd_chk("rst_status", 2'd1, 32'h0);
    rd_chk("rst_cnt", 2'd2, 32'h0);
    rd_chk("rst_thr", 2'd3, 32'h1);
    @(posedge clk);
    #1;
    rst_ni = 1'b1;
    step();

    // 1: plain enable reaches ACTIVE two cycles after the write
    cfg_wr(2'd0, 32'h1);
    chk("t1_state_mid", 32'(state_o), 32'd0);
    step();
    chk_outs("t1", 2'd2, 1'b1, 1'b0, 1'b0, 1'b0);

    // 2: auto-arm, threshold 2, trap handshake
    cfg_wr(2'd0, 32'h0);
    step();
    chk("t2_idle", 32'(state_o), 32'd0);
    cfg_wr(2'd3, 32'h2);
    cfg_wr(2'd0, 32'hB);
    step();
    chk_outs("t2_wait", 2'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    arm_marker_i = 1'b1;
    step();
    arm_marker_i = 1'b0;
    chk_outs("t2_arm", 2'd2, 1'b1, 1'b0, 1'b0, 1'b0);
    viol_i = 2'b01;
    step();
    viol_i = 2'b00;
    chk_outs("t2_v1", 2'd2, 1'b1, 1'b0, 1'b0, 1'b0);
    rd_chk("t2_cnt1", 2'd2, 32'd1);
    viol_i = 2'b10;
    step();
    viol_i = 2'b00;
    chk_outs("t2_trap", 2'd3, 1'b0, 1'b1, 1'b1, 1'b0);
    rd_chk("t2_cnt2", 2'd2, 32'd2);
    repeat (5) step();
    chk_outs("t2_hold", 2'd3, 1'b0, 1'b1, 1'b1, 1'b0);
    exc_ack_i = 1'b1;
    step();
    exc_ack_i = 1'b0;
    chk_outs("t2_ack", 2'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    rd_chk("t2_status", 2'd1, 32'hF);

    // 3: double violation, ack outside TRAP, saturation
    cfg_wr(2'd0, 32'h1);
    arm_marker_i = 1'b1;
    step();
    arm_marker_i = 1'b0;
    chk("t3_active", 32'(state_o), 32'd2);
    cfg_wr(2'd2, 32'h0);
    cfg_wr(2'd1, 32'hF);
    exc_ack_i = 1'b1;
    step();
    exc_ack_i = 1'b0;
    rd_chk("t3_ack_ignored", 2'd1, 32'h0);
    rd_chk("t3_cnt_clr", 2'd2, 32'h0);
    viol_i = 2'b11;
    step();
    viol_i = 2'b00;
    rd_chk("t3_cnt2", 2'd2, 32'd2);
    rd_chk("t3_cause", 2'd1, 32'h7);
    viol_i = 2'b11;
    repeat (32766) step();
    viol_i = 2'b00;
    rd_chk("t3_cnt_fffe", 2'd2, 32'hFFFE);
    viol_i = 2'b01;
    step();
    viol_i = 2'b00;
    rd_chk("t3_cnt_ffff", 2'd2, 32'hFFFF);
    viol_i = 2'b11;
    step();
    viol_i = 2'b00;
    rd_chk("t3_cnt_sat", 2'd2, 32'hFFFF);
    chk("t3_no_trap", 32'(state_o), 32'd2);

    // 4: interrupt and W1C versus same-cycle set
    cfg_wr(2'd1, 32'hF);
    cfg_wr(2'd0, 32'h5);
    chk("t4_irq0", 32'(irq_o), 32'd0);
    viol_i = 2'b01;
    step();
    viol_i = 2'b00;
    chk("t4_irq1", 32'(irq_o), 32'd1);
    cfg_if.cfg_we_i    = 1'b1;
    cfg_if.cfg_addr_i  = 2'd1;
    cfg_if.cfg_wdata_i = 32'h1;
    viol_i = 2'b10;
    step();
    cfg_if.cfg_we_i = 1'b0;
    viol_i = 2'b00;
    chk("t4_irq_kept", 32'(irq_o), 32'd1);
    rd_chk("t4_status_set_wins", 2'd1, 32'h7);
    cfg_wr(2'd1, 32'h1);
    chk("t4_irq_clr", 32'(irq_o), 32'd0);
    rd_chk("t4_status_w1c", 2'd1, 32'h6);

    // 5: counter clear with same-cycle violation; disable beats arm
    cfg_if.cfg_we_i    = 1'b1;
    cfg_if.cfg_addr_i  = 2'd2;
    cfg_if.cfg_wdata_i = 32'h1234;
    viol_i = 2'b01;
    step();
    cfg_if.cfg_we_i = 1'b0;
    viol_i = 2'b00;
    rd_chk("t5_cnt_clr_add", 2'd2, 32'd1);
    cfg_wr(2'd0, 32'h0);
    step();
    cfg_wr(2'd0, 32'h9);
    step();
    chk("t5_wait", 32'(state_o), 32'd1);
    cfg_wr(2'd0, 32'h0);
    arm_marker_i = 1'b1;
    step();
    arm_marker_i = 1'b0;
    chk_outs("t5_idle", 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    // 6: threshold 0 acts as 1; async reset during TRAP
    cfg_wr(2'd3, 32'h0);
    cfg_wr(2'd0, 32'h3);
    step();
    chk("t6_active", 32'(state_o), 32'd2);
    cfg_wr(2'd2, 32'h0);
    viol_i = 2'b01;
    step();
    viol_i = 2'b00;
    chk_outs("t6_trap", 2'd3, 1'b0, 1'b1, 1'b1, 1'b0);
    #2;
    rst_ni = 1'b0;
    #1;
    chk_outs("t6_async", 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    rd_chk("t6_ctrl", 2'd0, 32'h0);
    rd_chk("t6_status", 2'd1, 32'h0);
    rd_chk("t6_cnt", 2'd2, 32'h0);
    rd_chk("t6_thr", 2'd3, 32'h1);
    rst_ni = 1'b1;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
